legv8_instr_encoder: RTL and testbench

- Inverse of the immediate sign-extension path: accepts decoded LDUR/STUR/CBZ operations carrying a full 64-bit signed immediate and packs each into a 32-bit LEGv8 instruction word.
- Range-checks the immediate, so that truncation followed by sign extension restores the original value.
- Emits encoded words with sequential instruction-memory word addresses over a valid/ready stream.
- Used by the bench/loader side to fill the instruction memory of the single-cycle processor.

---
 rtl/legv8_pkg.sv | 46 ++++
 rtl/legv8_instr_encoder_imm_range_check.sv | 23 ++
 rtl/legv8_instr_encoder.sv | 111 +++++++++++
 tb/tb_legv8_instr_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoder types, opcode constants and the instruction-word packer.
package legv8_pkg;

    localparam int unsigned IMM_W    = 64;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned DT_IMM_W = 9;
    localparam int unsigned CB_IMM_W = 19;

    typedef enum logic [1:0] {
        OP_LDUR = 2'b00,
        OP_STUR = 2'b01,
        OP_CBZ  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;

    typedef struct packed {
        op_e              op;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rn;
        logic [IMM_W-1:0] imm;
    } enc_req_t;

    // D-format for loads/stores, CB-format for CBZ; field holds the truncated immediate
    function automatic logic [INSTR_W-1:0] encode_word(
        input op_e                 op,
        input logic [REG_W-1:0]    rt,
        input logic [REG_W-1:0]    rn,
        input logic [CB_IMM_W-1:0] field
    );
        logic [INSTR_W-1:0] word;
        word = '0;
        unique case (op)
            OP_LDUR: word = {OPC_LDUR, field[DT_IMM_W-1:0], 2'b00, rn, rt};
            OP_STUR: word = {OPC_STUR, field[DT_IMM_W-1:0], 2'b00, rn, rt};
            OP_CBZ:  word = {OPC_CBZ, field, rt};
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/legv8_instr_encoder_imm_range_check.sv
// Signed-fit check of a 64-bit immediate against a 9-bit or 19-bit field.
module imm_range_check
    import legv8_pkg::*;
(
    input  logic [IMM_W-1:0]    imm,
    input  logic                wide,
    output logic                fits_c,
    output logic [CB_IMM_W-1:0] field_c
);

    logic [IMM_W-DT_IMM_W:0] dt_upper;
    logic [IMM_W-CB_IMM_W:0] cb_upper;

    // Upper bits including the field's sign bit must be all-zero or all-one
    always_comb begin
        dt_upper = imm[IMM_W-1:DT_IMM_W-1];
        cb_upper = imm[IMM_W-1:CB_IMM_W-1];
        fits_c   = wide ? ((&cb_upper) || !(|cb_upper))
                        : ((&dt_upper) || !(|dt_upper));
        field_c  = imm[CB_IMM_W-1:0];
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Packs LDUR/STUR/CBZ operations into LEGv8 words on a one-deep valid/ready stream.
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [REG_W-1:0]    in_rt,
    input  logic [REG_W-1:0]    in_rn,
    input  logic [IMM_W-1:0]    in_imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                err,
    output logic [7:0]          err_count,
    output logic [ADDR_W:0]     emit_count
);

    localparam int unsigned      CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] EMIT_MAX  = CNT_W'(1) << ADDR_W;
    localparam logic [7:0]       ERR_MAX   = 8'hFF;

    enc_req_t              req;
    logic                  fits_c;
    logic [CB_IMM_W-1:0]   field_c;
    logic                  legal;
    logic                  accept;
    logic                  take;
    logic                  reject;
    logic                  drain;
    logic [INSTR_W-1:0]    word;

    logic                  out_valid_d;
    logic [INSTR_W-1:0]    out_instr_d;
    logic [ADDR_W-1:0]     out_addr_d;
    logic [ADDR_W-1:0]     next_addr, next_addr_d;
    logic                  err_d;
    logic [7:0]            err_count_d;
    logic [CNT_W-1:0]      emit_count_d;

    assign req = '{op: op_e'(in_op), rt: in_rt, rn: in_rn, imm: in_imm};

    imm_range_check u_range (
        .imm     (req.imm),
        .wide    (req.op == OP_CBZ),
        .fits_c  (fits_c),
        .field_c (field_c)
    );

    // Handshake: the output slot frees up in the same cycle it drains
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        legal    = fits_c && (req.op != OP_RSVD);
        take     = accept && legal;
        reject   = accept && !legal;
        drain    = out_valid && out_ready;
        word     = encode_word(req.op, req.rt, req.rn, field_c);
    end

    // Next-state: a legal accept loads the slot; a rejected one only bumps error state
    always_comb begin
        out_valid_d  = out_valid;
        out_instr_d  = out_instr;
        out_addr_d   = out_addr;
        next_addr_d  = next_addr;
        err_d        = err;
        err_count_d  = err_count;
        emit_count_d = emit_count;
        if (take) begin
            out_valid_d = 1'b1;
            out_instr_d = word;
            out_addr_d  = next_addr;
            next_addr_d = next_addr + ADDR_W'(1);
            if (emit_count != EMIT_MAX) emit_count_d = emit_count + CNT_W'(1);
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
        if (reject) begin
            err_d = 1'b1;
            if (err_count != ERR_MAX) err_count_d = err_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_addr   <= BASE_ADDR;
            next_addr  <= BASE_ADDR;
            err        <= 1'b0;
            err_count  <= '0;
            emit_count <= '0;
        end else begin
            out_valid  <= out_valid_d;
            out_instr  <= out_instr_d;
            out_addr   <= out_addr_d;
            next_addr  <= next_addr_d;
            err        <= err_d;
            err_count  <= err_count_d;
            emit_count <= emit_count_d;
        end
    end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed vector bench for legv8_instr_encoder: encoding table, stall, wrap, async reset.
module tb_legv8_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [1:0]  in_op;
    logic [4:0]  in_rt, in_rn;
    logic [63:0] in_imm;
    logic [31:0] out_instr;
    logic [5:0]  out_addr;
    logic [7:0]  err_count;
    logic [6:0]  emit_count;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_err;
    logic [1:0]  s_in_op;
    logic [4:0]  s_in_rt, s_in_rn;
    logic [63:0] s_in_imm;
    logic [31:0] s_out_instr;
    logic [1:0]  s_out_addr;
    logic [7:0]  s_err_count;
    logic [2:0]  s_emit_count;

    legv8_instr_encoder #(.ADDR_W(6), .BASE_ADDR(6'd0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rt(in_rt), .in_rn(in_rn), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .err_count(err_count), .emit_count(emit_count)
    );

    legv8_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut_small (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
        .in_rt(s_in_rt), .in_rn(s_in_rn), .in_imm(s_in_imm),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_instr(s_out_instr),
        .out_addr(s_out_addr), .err(s_err), .err_count(s_err_count), .emit_count(s_emit_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rt;
        logic [4:0]  rn;
        logic [63:0] imm;
        logic        legal;
        logic [31:0] instr;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int exp_addr, exp_err, exp_emit;

    initial begin
        vecs[0]  = '{2'b00, 5'd0,  5'd0,  64'd256,                   1'b0, 32'h0};
        vecs[1]  = '{2'b10, 5'd0,  5'd0,  64'd262144,                1'b0, 32'h0};
        vecs[2]  = '{2'b11, 5'd0,  5'd0,  64'd0,                     1'b0, 32'h0};
        vecs[3]  = '{2'b00, 5'd1,  5'd2,  64'hFFFF_FFFF_FFFF_FFF8,   1'b1, 32'hF85F_8041};
        vecs[4]  = '{2'b01, 5'd3,  5'd4,  64'd255,                   1'b1, 32'hF80F_F083};
        vecs[5]  = '{2'b10, 5'd5,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF,   1'b1, 32'hB4FF_FFE5};
        vecs[6]  = '{2'b00, 5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FEFF,   1'b0, 32'h0};
        vecs[7]  = '{2'b00, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FF00,   1'b1, 32'hF850_03FF};
        vecs[8]  = '{2'b01, 5'd5,  5'd5,  64'h8000_0000_0000_0000,   1'b0, 32'h0};
        vecs[9]  = '{2'b01, 5'd0,  5'd0,  64'd0,                     1'b1, 32'hF800_0000};
        vecs[10] = '{2'b10, 5'd7,  5'd0,  64'h3_FFFF,                1'b1, 32'hB47F_FFE7};
        vecs[11] = '{2'b10, 5'd0,  5'd0,  64'hFFFF_FFFF_FFFB_FFFF,   1'b0, 32'h0};
        vecs[12] = '{2'b10, 5'd0,  5'd0,  64'hFFFF_FFFF_FFFC_0000,   1'b1, 32'hB480_0000};
        vecs[13] = '{2'b11, 5'd1,  5'd2,  64'hFFFF_FFFF_FFFF_FFF8,   1'b0, 32'h0};
        vecs[14] = '{2'b10, 5'd2,  5'd31, 64'd4,                     1'b1, 32'hB400_0082};
        vecs[15] = '{2'b10, 5'd1,  5'd0,  64'd256,                   1'b1, 32'hB400_2001};

        in_valid = 0; in_op = 0; in_rt = 0; in_rn = 0; in_imm = 0; out_ready = 0;
        s_in_valid = 0; s_in_op = 0; s_in_rt = 0; s_in_rn = 0; s_in_imm = 0; s_out_ready = 0;
        exp_addr = 0; exp_err = 0; exp_emit = 0;

        #12;
        chk("rst_out_valid",  64'(out_valid), 64'd0);
        chk("rst_out_instr",  64'(out_instr), 64'd0);
        chk("rst_out_addr",   64'(out_addr), 64'd0);
        chk("rst_err",        64'(err), 64'd0);
        chk("rst_err_count",  64'(err_count), 64'd0);
        chk("rst_emit_count", 64'(emit_count), 64'd0);
        chk("rst_in_ready",   64'(in_ready), 64'd1);
        @(negedge clk) reset = 1;

        // Back-to-back stream with the consumer always ready
        out_ready = 1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1; in_op = vecs[i].op; in_rt = vecs[i].rt;
            in_rn = vecs[i].rn; in_imm = vecs[i].imm;
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
            step();
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].legal));
            if (vecs[i].legal) begin
                chk($sformatf("v%0d_instr", i), 64'(out_instr), 64'(vecs[i].instr));
                chk($sformatf("v%0d_addr", i), 64'(out_addr), 64'(exp_addr));
                exp_addr = (exp_addr + 1) % 64;
                exp_emit++;
            end else begin
                exp_err++;
            end
            chk($sformatf("v%0d_err", i), 64'(err), 64'(exp_err != 0));
            chk($sformatf("v%0d_err_count", i), 64'(err_count), 64'(exp_err));
            chk($sformatf("v%0d_emit_count", i), 64'(emit_count), 64'(exp_emit));
        end
        in_valid = 0;
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Back-pressure: word held, waiting op stalls, then drain+accept in one cycle
        in_valid = 1; in_op = 2'b01; in_rt = 5'd3; in_rn = 5'd4; in_imm = 64'd255; out_ready = 0;
        step();
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_addr",  64'(out_addr), 64'(exp_addr));
        in_op = 2'b10; in_rt = 5'd5; in_rn = 5'd0; in_imm = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("hold%0d_instr", k), 64'(out_instr), 64'h0000_0000_F80F_F083);
            chk($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
        end
        out_ready = 1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("swap_valid", 64'(out_valid), 64'd1);
        chk("swap_instr", 64'(out_instr), 64'h0000_0000_B4FF_FFE5);
        chk("swap_addr",  64'(out_addr), 64'(exp_addr + 1));
        exp_addr += 2; exp_emit += 2;
        in_valid = 0;
        step();
        chk("after_swap_valid", 64'(out_valid), 64'd0);
        step();
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_addr",  64'(out_addr), 64'(exp_addr - 1));
        chk("idle_emit",  64'(emit_count), 64'(exp_emit));

        // Four-word memory: wrap of address, saturation of emit_count
        s_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1; s_in_op = 2'b00; s_in_rt = 5'(i); s_in_rn = 5'd0; s_in_imm = 64'd0;
            step();
            chk($sformatf("w%0d_addr", i), 64'(s_out_addr), 64'(i % 4));
            chk($sformatf("w%0d_emit", i), 64'(s_emit_count), 64'((i + 1 > 4) ? 4 : i + 1));
            chk($sformatf("w%0d_instr", i), 64'(s_out_instr), 64'(32'hF840_0000 | 32'(i)));
        end
        s_in_valid = 0;

        // Async reset while a word is held and err is set
        in_valid = 1; in_op = 2'b00; in_rt = 5'd1; in_rn = 5'd2;
        in_imm = 64'hFFFF_FFFF_FFFF_FFF8; out_ready = 0;
        step();
        in_valid = 0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_err",   64'(err), 64'd1);
        @(negedge clk) reset = 0;
        #1;
        chk("arst_valid",      64'(out_valid), 64'd0);
        chk("arst_instr",      64'(out_instr), 64'd0);
        chk("arst_addr",       64'(out_addr), 64'd0);
        chk("arst_err",        64'(err), 64'd0);
        chk("arst_err_count",  64'(err_count), 64'd0);
        chk("arst_emit_count", 64'(emit_count), 64'd0);
        @(negedge clk) reset = 1;
        in_valid = 1; out_ready = 1;
        step();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_instr", 64'(out_instr), 64'h0000_0000_F85F_8041);
        chk("post_rst_addr",  64'(out_addr), 64'd0);
        chk("post_rst_emit",  64'(emit_count), 64'd1);
        in_valid = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
